// File: rtl/decrypt_mem.sv
// decrypt_mem: RC4 PRGA decrypt stage of the key-search datapath.
// Walks the shared S memory to produce one keystream byte per message byte,
// XORs it with the encrypted ROM and writes the result into the decrypted RAM.
// Every memory has a 2-cycle read latency, so each read spends READ/HOLD/SAVE
// states and the byte loop takes 15 cycles.
// Optional feature macro: DECRYPT_ASCII_CHECK_EN
//   defined   : each decrypted byte must be 'a'..'z' or space; the first
//               failing byte ends the run in DONE with key_valid=0.
//   undefined : no check; key_valid=1 whenever done=1.
module decrypt_mem #(
  parameter int MSG_LEN = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        s_q,
  output logic [7:0]        s_address,
  output logic [7:0]        s_data,
  output logic              s_wren,
  input  logic [7:0]        e_q,
  output logic [ADDR_W-1:0] e_address,
  output logic [ADDR_W-1:0] d_address,
  output logic [7:0]        d_data,
  output logic              d_wren,
  output logic              done,
  output logic              key_valid
);

  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(MSG_LEN - 1);

  typedef enum logic [4:0] {
    IDLE,
    INC_I,
    READ_I,
    HOLD_I,
    SAVE_I,
    CALC_J,
    READ_J,
    HOLD_J,
    SAVE_J,
    WRITE_J,
    WRITE_I,
    READ_F,
    HOLD_F,
    SAVE_F,
    WRITE_D,
    CHECK_DONE,
    DONE
  } state_t;

  state_t            r_state;
  logic [7:0]        r_i;
  logic [7:0]        r_j;
  logic [ADDR_W-1:0] r_k;
  logic [7:0]        r_si;
  logic [7:0]        r_sj;
  logic [7:0]        r_f;
  logic [7:0]        r_e;
  logic [7:0]        r_s_address;
  logic [7:0]        r_s_data;
  logic              r_s_wren;
  logic [ADDR_W-1:0] r_d_address;
  logic              r_d_wren;
  logic              r_done;
  logic              r_key_valid;

  logic [7:0]        w_d_byte;

  // The decrypted byte is built only from registered f and the sampled ROM byte.
  assign w_d_byte  = r_f ^ r_e;

  assign s_address = r_s_address;
  assign s_data    = r_s_data;
  assign s_wren    = r_s_wren;
  assign e_address = r_k;
  assign d_address = r_d_address;
  assign d_data    = w_d_byte;
  assign d_wren    = r_d_wren;
  assign done      = r_done;
  assign key_valid = r_key_valid;

`ifdef DECRYPT_ASCII_CHECK_EN
  logic w_ascii_ok;

  // Plausible plaintext is lowercase letters or space.
  assign w_ascii_ok = ((w_d_byte >= 8'h61) && (w_d_byte <= 8'h7A)) || (w_d_byte == 8'h20);
`endif

  // PRGA sequencer; memory-side outputs are registered on entry to the state that uses them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_i         <= 8'd0;
      r_j         <= 8'd0;
      r_k         <= '0;
      r_si        <= 8'd0;
      r_sj        <= 8'd0;
      r_f         <= 8'd0;
      r_e         <= 8'd0;
      r_s_address <= 8'd0;
      r_s_data    <= 8'd0;
      r_s_wren    <= 1'b0;
      r_d_address <= '0;
      r_d_wren    <= 1'b0;
      r_done      <= 1'b0;
      r_key_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_i     <= 8'd0;
            r_j     <= 8'd0;
            r_k     <= '0;
            r_state <= INC_I;
          end
        end
        INC_I: begin
          r_i         <= r_i + 8'd1;
          r_s_address <= r_i + 8'd1;
          r_state     <= READ_I;
        end
        READ_I: r_state <= HOLD_I;
        HOLD_I: r_state <= SAVE_I;
        SAVE_I: begin
          r_si    <= s_q;
          r_state <= CALC_J;
        end
        CALC_J: begin
          r_j         <= r_j + r_si;
          r_s_address <= r_j + r_si;
          r_state     <= READ_J;
        end
        READ_J: r_state <= HOLD_J;
        HOLD_J: r_state <= SAVE_J;
        SAVE_J: begin
          // First swap write (S[i] = sj) is set up directly from the read data.
          r_sj        <= s_q;
          r_s_address <= r_i;
          r_s_data    <= s_q;
          r_s_wren    <= 1'b1;
          r_state     <= WRITE_J;
        end
        WRITE_J: begin
          // Second write lands last, so i==j leaves the original value in place.
          r_s_address <= r_j;
          r_s_data    <= r_si;
          r_state     <= WRITE_I;
        end
        WRITE_I: begin
          r_s_wren    <= 1'b0;
          r_s_address <= r_si + r_sj;
          r_state     <= READ_F;
        end
        READ_F: r_state <= HOLD_F;
        HOLD_F: r_state <= SAVE_F;
        SAVE_F: begin
          r_f         <= s_q;
          r_e         <= e_q;
          r_d_address <= r_k;
          r_d_wren    <= 1'b1;
          r_state     <= WRITE_D;
        end
        WRITE_D: begin
          r_d_wren <= 1'b0;
`ifdef DECRYPT_ASCII_CHECK_EN
          if (!w_ascii_ok) begin
            r_state     <= DONE;
            r_done      <= 1'b1;
            r_key_valid <= 1'b0;
          end else begin
            r_state <= CHECK_DONE;
          end
`else
          r_state <= CHECK_DONE;
`endif
        end
        CHECK_DONE: begin
          if (r_k == LAST_K) begin
            r_state     <= DONE;
            r_done      <= 1'b1;
            r_key_valid <= 1'b1;
          end else begin
            r_k     <= r_k + 1'b1;
            r_state <= INC_I;
          end
        end
        DONE: begin
          if (!start) begin
            r_done      <= 1'b0;
            r_key_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/decrypt_mem.md
Name: decrypt_mem

Overview:
- Third and final stage of the RC4 key-search datapath; runs after the KSA shuffle stage has finished.
- Executes the RC4 PRGA over the shared 256x8 S working memory to produce one keystream byte per message byte.
- XORs each keystream byte with the encrypted-message ROM and writes the result to the decrypted-message RAM.
- Raises done and key_valid so the key-search controller can accept the key or advance to the next one.

Parameters:
MSG_LEN, 32, number of message bytes processed; 1..2^ADDR_W
ADDR_W, 5, address width of the encrypted ROM and decrypted RAM

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset (reset==0 on a rising clk edge resets the block)
start  input  1  level request; sampled only in IDLE
s_q  input  8  S memory read data
s_address  output  8  S memory address
s_data  output  8  S memory write data
s_wren  output  1  S memory write enable
e_q  input  8  encrypted ROM read data
e_address  output  ADDR_W  encrypted ROM address
d_address  output  ADDR_W  decrypted RAM address
d_data  output  8  decrypted RAM write data
d_wren  output  1  decrypted RAM write enable
done  output  1  high while in DONE
key_valid  output  1  result flag; meaningful only while done==1

Behaviour:
- Memory timing: all memories are synchronous with 2-cycle read latency.
  - FSM holds an address through READ_x and HOLD_x, then samples q in SAVE_x.
  - Writes commit on the edge that ends the state in which wren is high.
- Reset: state=IDLE. i, j, k, si, sj, f = 0. All addresses, data and wren outputs = 0. done = 0, key_valid = 0.
- Reset mid-operation: abort, return to IDLE next edge, wren outputs low. Partial memory contents are left as-is.
- Algorithm, 8-bit arithmetic, all sums mod 256. Starting from i=j=0, for k = 0..MSG_LEN-1:
  - i=i+1; si=S[i]; j=j+si; sj=S[j]
  - S[i]=sj; S[j]=si
  - f=S[si+sj]; D[k]=f^E[k]
- FSM, one state per cycle:
  - IDLE: start==1 -> INC_I, clearing i, j, k. Otherwise stay.
  - INC_I: i<=i+1.
  - READ_I, HOLD_I: s_address=i.
  - SAVE_I: si<=s_q.
  - CALC_J: j<=j+si.
  - READ_J, HOLD_J: s_address=j.
  - SAVE_J: sj<=s_q.
  - WRITE_J: s_address=i, s_data=sj, s_wren=1.
  - WRITE_I: s_address=j, s_data=si, s_wren=1.
  - READ_F, HOLD_F: s_address=si+sj.
  - SAVE_F: f<=s_q, and e_q sampled.
  - WRITE_D: d_address=k, d_data=f^e_q(sampled), d_wren=1.
  - CHECK_DONE: if k==MSG_LEN-1 -> DONE. Otherwise k<=k+1 -> INC_I.
  - DONE: done=1; stay while start==1; start==0 -> IDLE with done=0.
- e_address = k at all times; k is stable for far more than 2 cycles before SAVE_F.
- Latency: 15 cycles per byte. DONE is entered on the 15*MSG_LEN-th edge after the edge that samples start in IDLE.
- i==j: both writes target the same address. The second write (si) wins, which equals the original value, as RC4 requires.
- The F read occurs after both swap writes, so it observes the swapped S.
- s_wren and d_wren are never high at the same time. Each wren is high for exactly one cycle per write.
- The block does not re-initialise S; the upstream stages must rerun before every new start.

Optional Feature:
- Macro: DECRYPT_ASCII_CHECK_EN.
- Defined:
  - In WRITE_D, the written byte is tested for membership in 0x61..0x7A or 0x20.
  - On a failing byte, the write still occurs, the next state is DONE (fail-fast, skipping CHECK_DONE), and key_valid=0.
  - If all MSG_LEN bytes pass, key_valid=1 in DONE.
- Undefined: no check is made; key_valid=1 whenever in DONE.

Test Plan:
- Identity S (S[x]=x), E all 0x00, start=1, MSG_LEN=3 build -> D[0]=0x02, D[1]=0x05, D[2]=0x07; after the run, S[2]=0x03, S[3]=0x05, S[5]=0x02; done rises on edge 45.
- State walk, identity S, MSG_LEN=2 -> states visit INC_I..CHECK_DONE twice in the listed order, then DONE; s_wren high only in WRITE_J/WRITE_I, d_wren high only in WRITE_D.
- S preloaded with the KSA of key "Key" (0x4B6579), E[0]=0xBB, macro undefined -> D[0]=0x50 ('P', keystream 0xEB), key_valid=1.
- Macro defined, identity S, E[0]=0x63 -> D[0]=0x61 passes; E[1]=0x00 -> D[1]=0x05 fails; DONE is entered directly after WRITE_D of k=1, key_valid=0, and D[2] is never written.
- Reset=0 asserted during HOLD_J of byte 1 -> IDLE next edge, all outputs 0; reload identity S, start again -> D[0]=0x02.
- Hold start=1 in DONE for 10 cycles -> done stays 1 and no memory writes occur; drop start -> IDLE, done=0.
